mem_req_responder: RTL

MEM_REQ_RESPONDER -- requirements
Module: mem_req_responder

---
 rtl/mem_req_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_req_responder.sv
// mem_req_responder: single-port memory model that services a request FIFO
// (NOOP/REFRESH/READ/WRITE) and pushes read data into a response FIFO.
//
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-high reset
//   mem_req_rd_cmd/addr/dta - head of the request FIFO (cmd, word addr, wdata)
//   mem_req_rd_valid        - request FIFO non-empty
//   mem_req_rd_en           - request FIFO pop (combinational)
//   mem_res_wr_dta/en       - read response data and write strobe
//   mem_res_wr_almost_full  - response FIFO backpressure, blocks new transfers
//   rd_count/wr_count/refresh_count - accepted-command counters (wrap)
//   addr_error              - sticky out-of-range address flag
module mem_req_responder #(
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 2,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_req_rd_cmd,
  input  logic [21:0] mem_req_rd_addr,
  input  logic [63:0] mem_req_rd_dta,
  input  logic        mem_req_rd_valid,
  output logic        mem_req_rd_en,
  output logic [63:0] mem_res_wr_dta,
  output logic        mem_res_wr_en,
  input  logic        mem_res_wr_almost_full,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] refresh_count,
  output logic        addr_error
);

  typedef enum logic [1:0] {IDLE, BUSY_READ, BUSY_REFRESH} state_t;

  localparam logic [1:0] CMD_REFRESH = 2'd1;
  localparam logic [1:0] CMD_READ    = 2'd2;
  localparam logic [1:0] CMD_WRITE   = 2'd3;
  localparam logic [3:0] RD_LAT_M1   = 4'(READ_LATENCY - 1);
  localparam logic [3:0] REF_M1      = 4'(REFRESH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_mem [0:(2**ADDR_W)-1];
  logic [63:0] r_pend;
  logic [63:0] r_res_dta;
  logic        r_res_en;
  logic [15:0] r_rd_cnt, r_wr_cnt, r_ref_cnt;
  logic        r_err;

  logic              w_xfer, w_is_rd, w_is_wr, w_is_ref, w_oob, w_fire;
  logic [ADDR_W-1:0] w_idx;
  logic [63:0]       w_rword, w_fire_dta;

  assign mem_req_rd_en = (r_state == IDLE) && !mem_res_wr_almost_full && !reset;

  assign w_xfer   = mem_req_rd_en && mem_req_rd_valid;
  assign w_is_rd  = w_xfer && (mem_req_rd_cmd == CMD_READ);
  assign w_is_wr  = w_xfer && (mem_req_rd_cmd == CMD_WRITE);
  assign w_is_ref = w_xfer && (mem_req_rd_cmd == CMD_REFRESH);
  assign w_oob    = |mem_req_rd_addr[21:ADDR_W];
  assign w_idx    = mem_req_rd_addr[ADDR_W-1:0];
  // Array is read combinationally in the accept cycle, so a WRITE committed
  // at the previous edge is already visible (read-after-write).
  assign w_rword  = w_oob ? 64'h0 : r_mem[w_idx];

  // Response strobe is registered: it is set on the edge that ends cycle
  // T+READ_LATENCY-1. For latency 1 that is the accept edge itself.
  assign w_fire     = (w_is_rd && (RD_LAT_M1 == 4'd0)) ||
                      ((r_state == BUSY_READ) && (r_cnt == 4'd1));
  assign w_fire_dta = (r_state == BUSY_READ) ? r_pend : w_rword;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_is_rd) begin
          w_state_nxt = BUSY_READ;
          w_cnt_nxt   = RD_LAT_M1;
        end else if (w_is_ref) begin
          w_state_nxt = BUSY_REFRESH;
          w_cnt_nxt   = REF_M1;
        end
      end
      BUSY_READ, BUSY_REFRESH: begin
        // r_cnt counts down to 0; the cycle with r_cnt==0 is the last busy one
        if (r_cnt == 4'd0) w_state_nxt = IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_pend    <= 64'h0;
      r_res_en  <= 1'b0;
      r_res_dta <= 64'h0;
      r_rd_cnt  <= 16'h0;
      r_wr_cnt  <= 16'h0;
      r_ref_cnt <= 16'h0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_res_en <= w_fire;
      if (w_fire)   r_res_dta <= w_fire_dta;
      if (w_is_rd)  r_pend    <= w_rword;
      if (w_is_rd)  r_rd_cnt  <= r_rd_cnt + 16'd1;
      if (w_is_wr)  r_wr_cnt  <= r_wr_cnt + 16'd1;
      if (w_is_ref) r_ref_cnt <= r_ref_cnt + 16'd1;
      if ((w_is_rd || w_is_wr) && w_oob) r_err <= 1'b1;
    end
  end

  // Storage has no reset; writes are naturally blocked during reset since
  // mem_req_rd_en is forced low.
  always_ff @(posedge clk) begin
    if (w_is_wr && !w_oob) r_mem[w_idx] <= mem_req_rd_dta;
  end

  assign mem_res_wr_en  = r_res_en;
  assign mem_res_wr_dta = r_res_dta;
  assign rd_count       = r_rd_cnt;
  assign wr_count       = r_wr_cnt;
  assign refresh_count  = r_ref_cnt;
  assign addr_error     = r_err;

endmodule
